// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback-stage register file with write-through bypass and retire counter
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic              reg_write,
    input  logic [1:0]        mem_to_reg,
    input  logic [DATA_W-1:0] DFMEM_IN,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] ADD1_IN,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we,
    output logic [31:0]       retired_count
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [31:0]       cnt_q;
    logic [31:0]       cnt_d;

    always_comb begin
        wb_data = alu_result_in;
        case (mem_to_reg)
            2'b01:   wb_data = DFMEM_IN;
            2'b10:   wb_data = ADD1_IN;
            default: wb_data = alu_result_in;
        endcase
    end

    assign wb_we = wb_valid && reg_write && (write_reg != '0);

    // Register 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_we) begin
            regs_q[write_reg] <= wb_data;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (wb_valid) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign retired_count = cnt_q;

    // Bypass lets the ID stage see a value retiring in this same cycle.
    always_comb begin
        read_data1 = regs_q[read_reg1];
        if (read_reg1 == '0) begin
            read_data1 = '0;
        end else if (wb_we && (read_reg1 == write_reg)) begin
            read_data1 = wb_data;
        end
    end

    always_comb begin
        read_data2 = regs_q[read_reg2];
        if (read_reg2 == '0) begin
            read_data2 = '0;
        end else if (wb_we && (read_reg2 == write_reg)) begin
            read_data2 = wb_data;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed self-checking bench for wb_regfile
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic        reg_write;
    logic [1:0]  mem_to_reg;
    logic [31:0] DFMEM_IN;
    logic [31:0] alu_result_in;
    logic [31:0] ADD1_IN;
    logic [4:0]  write_reg;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] wb_data;
    logic        wb_we;
    logic [31:0] retired_count;

    int n_total;
    int n_bad;

    logic [1:0]  sel_tab [3];
    logic [31:0] exp_tab [3];

    wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_valid      (wb_valid),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .DFMEM_IN      (DFMEM_IN),
        .alu_result_in (alu_result_in),
        .ADD1_IN       (ADD1_IN),
        .write_reg     (write_reg),
        .read_reg1     (read_reg1),
        .read_reg2     (read_reg2),
        .read_data1    (read_data1),
        .read_data2    (read_data2),
        .wb_data       (wb_data),
        .wb_we         (wb_we),
        .retired_count (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        sel_tab[0] = 2'b01; exp_tab[0] = 32'hAAAA0001;
        sel_tab[1] = 2'b10; exp_tab[1] = 32'h00000104;
        sel_tab[2] = 2'b11; exp_tab[2] = 32'h00000012;

        rst = 1'b0; wb_valid = 1'b0; reg_write = 1'b0; mem_to_reg = 2'b00;
        DFMEM_IN = 32'hAAAA0001; alu_result_in = 32'h12; ADD1_IN = 32'h104;
        write_reg = 5'd0; read_reg1 = 5'd5; read_reg2 = 5'd7;
        #2;
        check("reset_rd1", read_data1, 32'h0);
        check("reset_rd2", read_data2, 32'h0);
        check("reset_cnt", retired_count, 32'h0);
        check("reset_we", {31'b0, wb_we}, 32'h0);
        check("reset_wbdata_comb", wb_data, 32'h12);

        @(negedge clk);
        rst = 1'b1;

        // Source select: each entry writes r5 and is read back through the array.
        for (int i = 0; i < 3; i++) begin
            wb_valid = 1'b1; reg_write = 1'b1; write_reg = 5'd5; mem_to_reg = sel_tab[i];
            #1;
            check("sel_wbdata", wb_data, exp_tab[i]);
            check("sel_we", {31'b0, wb_we}, 32'h1);
            step();
            wb_valid = 1'b0;
            #1;
            check("sel_r5", read_data1, exp_tab[i]);
        end
        check("cnt_after_sel", retired_count, 32'd3);

        wb_valid = 1'b1; reg_write = 1'b1; write_reg = 5'd0; mem_to_reg = 2'b00;
        alu_result_in = 32'hFFFFFFFF; read_reg1 = 5'd0;
        #1;
        check("r0_we", {31'b0, wb_we}, 32'h0);
        check("r0_rd1", read_data1, 32'h0);
        step();
        wb_valid = 1'b0;
        #1;
        check("r0_after", read_data1, 32'h0);
        check("cnt_r0", retired_count, 32'd4);

        wb_valid = 1'b1; reg_write = 1'b1; write_reg = 5'd7; alu_result_in = 32'h55;
        read_reg1 = 5'd7; read_reg2 = 5'd7;
        #1;
        check("byp_rd1", read_data1, 32'h55);
        check("byp_rd2", read_data2, 32'h55);
        step();
        wb_valid = 1'b0;
        #1;
        check("byp_r7_array", read_data1, 32'h55);

        alu_result_in = 32'h99;
        #1;
        check("nobyp_we", {31'b0, wb_we}, 32'h0);
        check("nobyp_rd1", read_data1, 32'h55);
        step();
        #1;
        check("nobyp_r7_kept", read_data1, 32'h55);
        read_reg2 = 5'd5;
        #1;
        check("indep_rd2_r5", read_data2, 32'h12);
        check("cnt_before_rst", retired_count, 32'd5);

        // Mid-run reset, then an edge with rst low while a write is presented.
        rst = 1'b0;
        #1;
        check("midrst_rd1", read_data1, 32'h0);
        check("midrst_rd2", read_data2, 32'h0);
        check("midrst_cnt", retired_count, 32'h0);
        wb_valid = 1'b1; alu_result_in = 32'h77;
        #1;
        check("rst_bypass", read_data1, 32'h77);
        step();
        wb_valid = 1'b0;
        #1;
        check("rst_write_blocked", read_data1, 32'h0);
        check("rst_cnt_blocked", retired_count, 32'h0);
        rst = 1'b1;
        #1;
        check("release_r7", read_data1, 32'h0);

        wb_valid = 1'b1; reg_write = 1'b1; write_reg = 5'd3; alu_result_in = 32'h33;
        step();
        wb_valid = 1'b0; read_reg1 = 5'd3;
        #1;
        check("post_rst_r3", read_data1, 32'h33);
        check("post_rst_cnt", retired_count, 32'd1);

        force dut.cnt_q = 32'hFFFFFFFE;
        #1;
        release dut.cnt_q;
        #1;
        check("cnt_preload", retired_count, 32'hFFFFFFFE);
        wb_valid = 1'b1; reg_write = 1'b0;
        step();
        check("cnt_ffff", retired_count, 32'hFFFFFFFF);
        step();
        check("cnt_wrap0", retired_count, 32'h0);
        step();
        check("cnt_wrap1", retired_count, 32'h1);
        #1;
        check("cnt_r3_kept", read_data1, 32'h33);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
